rf_tile4x4: RTL and testbench
=============================

# rf_tile4x4

Operand register file plus 4x4 output-stationary systolic multiply-accumulate tile. The block computes C = A x B for two 4x4 unsigned matrices and sits below the systolic-array top level. The host loads A and B with four indexed write cycles, then runs compute cycles while the register file streams skewed rows of A and columns of B into the PE grid. The sixteen accumulated results are exposed in parallel.

## Interface
- WIDTH, 8, operand element width (unsigned)
- ACC_W, 2*WIDTH+2, accumulator and result width; holds a full 4-term dot product without overflow
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- enable  in  1  global cycle enable; low = every register holds
- write  in  1  with enable: load cycle; enable & !write: compute cycle
- idx  in  2  load slot index k (0..3)
- d0..d3  in  WIDTH each  A[k][0..3], row k of A
- d4..d7  in  WIDTH each  B[0..3][k], column k of B
- y0..y15  out  ACC_W each  y[4i+j] = C[i][j], row-major
- done  out  1  high once C is complete

## Operation
- Register file holds A[4][4] and B[4][4].
- On a load cycle (enable=1, write=1), idx=k stores d0..d3 into A row k and d4..d7 into B column k. Other slots are unchanged. Rewriting a slot overwrites it.
- Every load cycle also does the following:
  - clears all 16 accumulators
  - resets the step counter t to 0
  - clears done
- The PE grid is 4x4. PE(i,j) holds accumulator acc[i][j] and forwards its a operand to the right and its b operand downward, both through registers.
- Row edge i is fed A[i][t-i]; column edge j is fed B[t-j][j]. Out-of-range indices feed 0.
- Net effect: at step t, PE(i,j) adds a*b with a = A[i][t-i-j] and b = B[t-i-j][j], or adds 0 when t-i-j is outside 0..3.
- Products are WIDTH x WIDTH unsigned, zero-extended to ACC_W. Accumulation wraps modulo 2^ACC_W (no overflow at default widths).
- Step counter t runs 0..9 on successive compute cycles. After step 9 completes, done=1 and t saturates.
- While done=1, further compute cycles change nothing.
- enable=0 freezes the counter, the pipelines, the accumulators, done and the register file.
- idx and d0..d7 are ignored on compute cycles.

## Timing
- Reset values:
  - y0..y15 = 0
  - done = 0
  - all A and B entries = 0
  - t = 0
  - all forwarding registers = 0
- A load takes effect at the clock edge of the load cycle. Compute may start on the next cycle.
- y outputs are registered. acc[i][j] reflects step t after the edge that ends step t.
- Latency is exactly 10 enabled compute cycles from the first compute cycle to done=1. done is registered and rises on the same edge as the final accumulator update.
- Stalls (enable=0) add cycles one-for-one and do not change results.
- A write in the middle of a computation aborts it:
  - accumulators are 0 and done=0 on the following cycle
  - A and B keep all slots not being rewritten
- Reset asserted mid-operation clears everything immediately (asynchronously). The first enabled edge after deassertion is treated as normal.
- There are no simultaneous-event conflicts: write has priority over compute by definition, since a load cycle never accumulates.

## Test plan
- Reset -> all y = 0 and done = 0.
- Load A = identity and B[r][c] = 4r+c+1 (slots 0..3), then run 10 compute cycles -> y[n] = n+1 and done rises on the 10th edge, not the 9th.
- Load A and B with all elements 255, then compute -> every y = 260100 and no wrap.
- Load A[i][k]=i+1, B[k][j]=j+1, then compute with enable dropped for 3 cycles at step 4 -> done after 13 cycles and y[4i+j] = 4(i+1)(j+1).
- Write idx=2 at step 5 of a running compute -> y all 0 and done=0 on the next cycle. Recompute -> results use the new row 2 / column 2 with other slots preserved.
- Assert reset at step 6 -> y and done clear immediately. Recompute after reloading -> correct C.

Source files
------------

// File: rtl/rf_tile4x4_if.sv
// rf_tile4x4 host bus: load/compute control, operand slot data, results.
// master = host (drives enable/write/idx/d*), slave = tile (drives y*/done).
interface rf_tile4x4_if #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH + 2
);
    logic             enable;
    logic             write;
    logic [1:0]       idx;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic [WIDTH-1:0] d4, d5, d6, d7;
    logic [ACC_W-1:0] y0, y1, y2, y3;
    logic [ACC_W-1:0] y4, y5, y6, y7;
    logic [ACC_W-1:0] y8, y9, y10, y11;
    logic [ACC_W-1:0] y12, y13, y14, y15;
    logic             done;

    modport master (
        output enable, write, idx,
        output d0, d1, d2, d3, d4, d5, d6, d7,
        input  y0, y1, y2, y3, y4, y5, y6, y7,
        input  y8, y9, y10, y11, y12, y13, y14, y15,
        input  done
    );

    modport slave (
        input  enable, write, idx,
        input  d0, d1, d2, d3, d4, d5, d6, d7,
        output y0, y1, y2, y3, y4, y5, y6, y7,
        output y8, y9, y10, y11, y12, y13, y14, y15,
        output done
    );
endinterface

// File: rtl/rf_tile4x4.sv
// Operand register file + 4x4 output-stationary systolic MAC tile (C = A x B).
// Ports: clk, reset (async active-low), bus (slave: load/compute in, y/done out).
module rf_tile4x4 #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH + 2
) (
    input  logic         clk,
    input  logic         reset,
    rf_tile4x4_if.slave  bus
);
    logic [WIDTH-1:0] A_q [4][4];
    logic [WIDTH-1:0] B_q [4][4];
    logic [WIDTH-1:0] a_q [4][4];
    logic [WIDTH-1:0] b_q [4][4];
    logic [WIDTH-1:0] a_d [4][4];
    logic [WIDTH-1:0] b_d [4][4];
    logic [ACC_W-1:0] acc_q [4][4];
    logic [ACC_W-1:0] acc_d [4][4];
    logic [WIDTH-1:0] ea [4];
    logic [WIDTH-1:0] eb [4];
    logic [WIDTH-1:0] d [8];
    logic [3:0]       t_q;
    logic             done_q;

    assign d[0] = bus.d0;
    assign d[1] = bus.d1;
    assign d[2] = bus.d2;
    assign d[3] = bus.d3;
    assign d[4] = bus.d4;
    assign d[5] = bus.d5;
    assign d[6] = bus.d6;
    assign d[7] = bus.d7;

    // Skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j],
    // zero whenever the index falls outside 0..3.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ea[i] = '0;
            eb[i] = '0;
            for (int k = 0; k < 4; k++) begin
                if (t_q == 4'(i + k)) begin
                    ea[i] = A_q[i][k];
                    eb[i] = B_q[k][i];
                end
            end
        end
    end

    // a travels right and b travels down, one register per PE hop.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_d[i][0] = ea[i];
            b_d[0][i] = eb[i];
            for (int j = 1; j < 4; j++) begin
                a_d[i][j] = a_q[i][j-1];
                b_d[j][i] = b_q[j-1][i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc_d[i][j] = acc_q[i][j]
                            + ACC_W'(a_d[i][j]) * ACC_W'(b_d[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    A_q[i][j]   <= '0;
                    B_q[i][j]   <= '0;
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end
            end
            t_q    <= '0;
            done_q <= 1'b0;
        end else if (bus.enable) begin
            if (bus.write) begin
                // Load also flushes the pipeline so an aborted run
                // leaves no stale operands behind.
                for (int c = 0; c < 4; c++) begin
                    A_q[bus.idx][c] <= d[c];
                    B_q[c][bus.idx] <= d[4+c];
                end
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        a_q[i][j]   <= '0;
                        b_q[i][j]   <= '0;
                        acc_q[i][j] <= '0;
                    end
                end
                t_q    <= '0;
                done_q <= 1'b0;
            end else if (!done_q) begin
                a_q   <= a_d;
                b_q   <= b_d;
                acc_q <= acc_d;
                if (t_q == 4'd9) begin
                    done_q <= 1'b1;
                end else begin
                    t_q <= t_q + 4'd1;
                end
            end
        end
    end

    assign bus.y0   = acc_q[0][0];
    assign bus.y1   = acc_q[0][1];
    assign bus.y2   = acc_q[0][2];
    assign bus.y3   = acc_q[0][3];
    assign bus.y4   = acc_q[1][0];
    assign bus.y5   = acc_q[1][1];
    assign bus.y6   = acc_q[1][2];
    assign bus.y7   = acc_q[1][3];
    assign bus.y8   = acc_q[2][0];
    assign bus.y9   = acc_q[2][1];
    assign bus.y10  = acc_q[2][2];
    assign bus.y11  = acc_q[2][3];
    assign bus.y12  = acc_q[3][0];
    assign bus.y13  = acc_q[3][1];
    assign bus.y14  = acc_q[3][2];
    assign bus.y15  = acc_q[3][3];
    assign bus.done = done_q;
endmodule

// File: tb/tb_rf_tile4x4.sv
// Directed bench for rf_tile4x4: loads, compute runs, stalls,
// mid-run write abort and mid-run async reset.
module tb_rf_tile4x4;
    localparam int W  = 8;
    localparam int AW = 2 * W + 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rf_tile4x4_if #(.WIDTH(W), .ACC_W(AW)) bus ();
    rf_tile4x4 #(.WIDTH(W), .ACC_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [AW-1:0] y [16];
    assign y[0]  = bus.y0;
    assign y[1]  = bus.y1;
    assign y[2]  = bus.y2;
    assign y[3]  = bus.y3;
    assign y[4]  = bus.y4;
    assign y[5]  = bus.y5;
    assign y[6]  = bus.y6;
    assign y[7]  = bus.y7;
    assign y[8]  = bus.y8;
    assign y[9]  = bus.y9;
    assign y[10] = bus.y10;
    assign y[11] = bus.y11;
    assign y[12] = bus.y12;
    assign y[13] = bus.y13;
    assign y[14] = bus.y14;
    assign y[15] = bus.y15;

    int ma [4][4];
    int mb [4][4];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic wr);
        bus.enable = en;
        bus.write  = wr;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        bus.write  = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cyc(1'b1, 1'b0);
    endtask

    task automatic load(input int k);
        bus.idx = 2'(k);
        bus.d0 = W'(ma[k][0]);
        bus.d1 = W'(ma[k][1]);
        bus.d2 = W'(ma[k][2]);
        bus.d3 = W'(ma[k][3]);
        bus.d4 = W'(mb[0][k]);
        bus.d5 = W'(mb[1][k]);
        bus.d6 = W'(mb[2][k]);
        bus.d7 = W'(mb[3][k]);
        cyc(1'b1, 1'b1);
    endtask

    task automatic load_all();
        for (int k = 0; k < 4; k++) load(k);
    endtask

    // Reference: acc(i,j) after step t sums terms with i+j+k <= t.
    function automatic int part(input int i, input int j, input int t);
        int s = 0;
        for (int k = 0; k < 4; k++)
            if (i + j + k <= t) s += ma[i][k] * mb[k][j];
        return s;
    endfunction

    task automatic chk_y(input string tag, input int t);
        for (int n = 0; n < 16; n++)
            chk($sformatf("%s_y%0d", tag, n), 64'(y[n]),
                64'(part(n / 4, n % 4, t)));
    endtask

    task automatic chk_zero(input string tag);
        for (int n = 0; n < 16; n++)
            chk($sformatf("%s_y%0d", tag, n), 64'(y[n]), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.write  = 1'b0;
        bus.idx    = 2'd0;
        {bus.d0, bus.d1, bus.d2, bus.d3} = '0;
        {bus.d4, bus.d5, bus.d6, bus.d7} = '0;

        #7;
        chk_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Identity x B, B[r][c] = 4r+c+1
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 1 : 0;
                mb[i][j] = 4 * i + j + 1;
            end
        load_all();
        chk("id_done_load", 64'(bus.done), 64'd0);
        run(9);
        chk("id_done_9", 64'(bus.done), 64'd0);
        chk_y("id_s8", 8);
        run(1);
        chk("id_done_10", 64'(bus.done), 64'd1);
        for (int n = 0; n < 16; n++)
            chk($sformatf("id_y%0d", n), 64'(y[n]), 64'(n + 1));
        run(2);
        chk("id_hold_done", 64'(bus.done), 64'd1);
        chk_y("id_hold", 9);

        // All 255: max dot product must not wrap
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 255;
                mb[i][j] = 255;
            end
        load_all();
        chk_zero("max_load");
        run(10);
        chk("max_done", 64'(bus.done), 64'd1);
        for (int n = 0; n < 16; n++)
            chk($sformatf("max_y%0d", n), 64'(y[n]), 64'd260100);

        // Stall 3 cycles at step 4
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = i + 1;
                mb[i][j] = j + 1;
            end
        load_all();
        run(4);
        repeat (3) cyc(1'b0, 1'b0);
        chk("stall_done", 64'(bus.done), 64'd0);
        chk_y("stall_s3", 3);
        run(5);
        chk("stall_done_12", 64'(bus.done), 64'd0);
        run(1);
        chk("stall_done_13", 64'(bus.done), 64'd1);
        for (int n = 0; n < 16; n++)
            chk($sformatf("stall_y%0d", n), 64'(y[n]),
                64'(4 * (n / 4 + 1) * (n % 4 + 1)));

        // Write idx=2 at step 5 aborts the run
        load_all();
        run(5);
        for (int c = 0; c < 4; c++) begin
            ma[2][c] = 9 - c;
            mb[c][2] = 5 - c;
        end
        load(2);
        chk_zero("abort");
        run(10);
        chk("abort_done", 64'(bus.done), 64'd1);
        chk_y("abort_re", 9);

        // Async reset at step 6
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (3 * i + 5 * j + 1) % 256;
                mb[i][j] = (7 * i + 2 * j + 11) % 256;
            end
        load_all();
        run(6);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("arst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(10);
        chk("arst_empty_done", 64'(bus.done), 64'd1);
        for (int n = 0; n < 16; n++)
            chk($sformatf("arst_empty_y%0d", n), 64'(y[n]), 64'd0);
        load_all();
        run(10);
        chk("arst_re_done", 64'(bus.done), 64'd1);
        chk_y("arst_re", 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
